// File: rtl/pixel_packer.sv
// pixel_packer: decimates a 1-bit pixel stream by (mult+1) and packs the
// samples MSB-first into WIDTH-bit words, offered on a valid/ready port.
// A word that completes while the previous one is still unconsumed is
// dropped and flagged with a one-cycle overflow pulse.
module pixel_packer #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clear,
    input  logic             enable,
    input  logic [3:0]       mult,
    input  logic             d,
    output logic [WIDTH-1:0] q,
    output logic             q_valid,
    input  logic             q_ready,
    output logic             overflow
);

    localparam int BW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
    localparam logic [BW-1:0] LAST_BIT = BW'(WIDTH - 1);

    logic [3:0]       rpt_q, rpt_d;
    logic [BW-1:0]    bit_q, bit_d;
    logic [WIDTH-1:0] sr_q, sr_d;
    logic [WIDTH-1:0] word_q, word_d;
    logic             valid_q, valid_d;
    logic             ovf_q, ovf_d;

    logic             sample, complete, accept;
    logic [WIDTH-1:0] word;

    assign sample   = !clear && enable && (rpt_q == mult);
    assign complete = sample && (bit_q == LAST_BIT);
    assign word     = {sr_q[WIDTH-2:0], d};
    assign accept   = valid_q && q_ready;

    // Repeat counter, bit counter and shift register; clear beats enable.
    always_comb begin
        rpt_d = rpt_q;
        bit_d = bit_q;
        sr_d  = sr_q;
        if (clear) begin
            rpt_d = '0;
            bit_d = '0;
            sr_d  = '0;
        end else if (enable) begin
            rpt_d = (rpt_q == mult) ? 4'd0 : 4'(rpt_q + 4'd1);
            if (sample) begin
                if (complete) begin
                    bit_d = '0;
                    sr_d  = '0;
                end else begin
                    bit_d = BW'(bit_q + 1'b1);
                    sr_d  = word;
                end
            end
        end
    end

    // Output slot: load on completion when free or being drained, else drop.
    always_comb begin
        word_d  = word_q;
        valid_d = valid_q;
        ovf_d   = complete && valid_q && !q_ready;
        if (complete && (!valid_q || accept)) begin
            word_d  = word;
            valid_d = 1'b1;
        end else if (accept) begin
            valid_d = 1'b0;
        end
    end

    // State registers, all cleared by the asynchronous reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rpt_q   <= '0;
            bit_q   <= '0;
            sr_q    <= '0;
            word_q  <= '0;
            valid_q <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            rpt_q   <= rpt_d;
            bit_q   <= bit_d;
            sr_q    <= sr_d;
            word_q  <= word_d;
            valid_q <= valid_d;
            ovf_q   <= ovf_d;
        end
    end

    assign q        = word_q;
    assign q_valid  = valid_q;
    assign overflow = ovf_q;

endmodule

// File: tb/tb_pixel_packer.sv
// Self-checking bench for pixel_packer (WIDTH=16). Expected words go into
// exp_q as stimulus is driven; the monitor records every accepted word in
// rx_q and each test pops and compares the two.
module tb_pixel_packer;

    localparam int W = 16;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         clear = 1'b0;
    logic         enable = 1'b0;
    logic [3:0]   mult = 4'd0;
    logic         d = 1'b0;
    logic [W-1:0] q;
    logic         q_valid;
    logic         q_ready = 1'b0;
    logic         overflow;

    int errors = 0;
    int checks = 0;
    int ovf_cnt = 0;
    logic [W-1:0] exp_q[$];
    logic [W-1:0] rx_q[$];

    pixel_packer #(.WIDTH(W)) dut (
        .clk(clk), .rst_n(rst_n), .clear(clear), .enable(enable),
        .mult(mult), .d(d), .q(q), .q_valid(q_valid), .q_ready(q_ready),
        .overflow(overflow)
    );

    always #5 clk = ~clk;

    // Monitor on the falling edge: record accepted words, count overflow pulses.
    always @(negedge clk) begin
        if (rst_n) begin
            if (q_valid && q_ready) rx_q.push_back(q);
            if (overflow) ovf_cnt++;
        end
    end

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            enable = 1'b0;
            clear = 1'b0;
            @(posedge clk); #1;
        end
    endtask

    // Send the top n bits of w MSB-first, each held for hold enabled cycles,
    // optionally interleaved with disabled cycles. early flags q_valid seen
    // before the final cycle.
    task automatic send_bits(input logic [W-1:0] w, input int n, input int hold,
                             input bit toggle, output bit early);
        early = 1'b0;
        for (int i = W - 1; i >= W - n; i--) begin
            for (int h = 0; h < hold; h++) begin
                if (toggle) begin
                    enable = 1'b0;
                    @(posedge clk); #1;
                    if (q_valid) early = 1'b1;
                end
                d = w[i];
                enable = 1'b1;
                @(posedge clk); #1;
                if (q_valid && !(i == W - n && h == hold - 1)) early = 1'b1;
            end
        end
        enable = 1'b0;
    endtask

    task automatic test_reset();
        checks++;
        if (q !== '0 || q_valid !== 1'b0 || overflow !== 1'b0) begin
            errors++;
            $display("FAIL reset_state: q=%h v=%b ovf=%b want 0/0/0", q, q_valid, overflow);
        end
        @(posedge clk); #1;
        rst_n = 1'b1;
        idle(2);
        checks++;
        if (q !== '0 || q_valid !== 1'b0 || overflow !== 1'b0) begin
            errors++;
            $display("FAIL reset_release: q=%h v=%b ovf=%b want 0/0/0", q, q_valid, overflow);
        end
    endtask

    task automatic test_basic();
        bit early;
        int ovf0 = ovf_cnt;
        logic [W-1:0] got, exp;
        mult = 4'd0;
        q_ready = 1'b1;
        exp_q.push_back(16'hA0F1);
        send_bits(16'hA0F1, 16, 1, 1'b0, early);
        checks++;
        if (early || q_valid !== 1'b1 || q !== 16'hA0F1) begin
            errors++;
            $display("FAIL basic_word: early=%b v=%b q=%h want 0/1/a0f1", early, q_valid, q);
        end
        idle(1);
        checks++;
        if (q_valid !== 1'b0) begin
            errors++;
            $display("FAIL basic_pulse: v=%b want 0", q_valid);
        end
        checks++;
        if (ovf_cnt != ovf0) begin
            errors++;
            $display("FAIL basic_ovf: pulses=%0d want 0", ovf_cnt - ovf0);
        end
        while (rx_q.size() > 0) begin
            got = rx_q.pop_front();
            exp = (exp_q.size() > 0) ? exp_q.pop_front() : 'x;
            checks++;
            if (got !== exp) begin
                errors++;
                $display("FAIL basic_sb: got=%h want %h", got, exp);
            end
        end
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL basic_missing: %0d words not seen", exp_q.size());
            exp_q.delete();
        end
    endtask

    task automatic test_repeat(input bit toggle);
        bit early;
        logic [W-1:0] got, exp;
        mult = 4'd2;
        q_ready = 1'b1;
        exp_q.push_back(16'h8001);
        send_bits(16'h8001, 16, 3, toggle, early);
        checks++;
        if (early || q_valid !== 1'b1 || q !== 16'h8001) begin
            errors++;
            $display("FAIL repeat_word(toggle=%0b): early=%b v=%b q=%h want 0/1/8001",
                     toggle, early, q_valid, q);
        end
        idle(1);
        while (rx_q.size() > 0) begin
            got = rx_q.pop_front();
            exp = (exp_q.size() > 0) ? exp_q.pop_front() : 'x;
            checks++;
            if (got !== exp) begin
                errors++;
                $display("FAIL repeat_sb: got=%h want %h", got, exp);
            end
        end
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL repeat_missing: %0d words not seen", exp_q.size());
            exp_q.delete();
        end
        mult = 4'd0;
    endtask

    task automatic test_overflow();
        bit early;
        int ovf0 = ovf_cnt;
        logic [W-1:0] got, exp;
        mult = 4'd0;
        q_ready = 1'b0;
        exp_q.push_back(16'h1234);
        send_bits(16'h1234, 16, 1, 1'b0, early);
        send_bits(16'hBEEF, 16, 1, 1'b0, early);
        checks++;
        if (overflow !== 1'b1 || q_valid !== 1'b1 || q !== 16'h1234) begin
            errors++;
            $display("FAIL ovf_pulse: ovf=%b v=%b q=%h want 1/1/1234", overflow, q_valid, q);
        end
        idle(1);
        checks++;
        if (overflow !== 1'b0 || ovf_cnt - ovf0 != 1) begin
            errors++;
            $display("FAIL ovf_once: ovf=%b pulses=%0d want 0/1", overflow, ovf_cnt - ovf0);
        end
        q_ready = 1'b1;
        idle(1);
        q_ready = 1'b0;
        checks++;
        if (q_valid !== 1'b0) begin
            errors++;
            $display("FAIL ovf_drain: v=%b want 0", q_valid);
        end
        while (rx_q.size() > 0) begin
            got = rx_q.pop_front();
            exp = (exp_q.size() > 0) ? exp_q.pop_front() : 'x;
            checks++;
            if (got !== exp) begin
                errors++;
                $display("FAIL ovf_sb: got=%h want %h", got, exp);
            end
        end
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL ovf_missing: %0d words not seen", exp_q.size());
            exp_q.delete();
        end
    endtask

    task automatic test_back_to_back();
        bit early;
        int ovf0 = ovf_cnt;
        logic [W-1:0] got, exp;
        mult = 4'd0;
        q_ready = 1'b1;
        exp_q.push_back(16'hFFFF);
        exp_q.push_back(16'h0000);
        send_bits(16'hFFFF, 16, 1, 1'b0, early);
        checks++;
        if (q_valid !== 1'b1 || q !== 16'hFFFF) begin
            errors++;
            $display("FAIL b2b_first: v=%b q=%h want 1/ffff", q_valid, q);
        end
        send_bits(16'h0000, 16, 1, 1'b0, early);
        checks++;
        if (q_valid !== 1'b1 || q !== 16'h0000) begin
            errors++;
            $display("FAIL b2b_second: v=%b q=%h want 1/0000", q_valid, q);
        end
        idle(1);
        checks++;
        if (ovf_cnt != ovf0) begin
            errors++;
            $display("FAIL b2b_ovf: pulses=%0d want 0", ovf_cnt - ovf0);
        end
        checks++;
        if (rx_q.size() != 2) begin
            errors++;
            $display("FAIL b2b_count: words=%0d want 2", rx_q.size());
        end
        while (rx_q.size() > 0) begin
            got = rx_q.pop_front();
            exp = (exp_q.size() > 0) ? exp_q.pop_front() : 'x;
            checks++;
            if (got !== exp) begin
                errors++;
                $display("FAIL b2b_sb: got=%h want %h", got, exp);
            end
        end
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL b2b_missing: %0d words not seen", exp_q.size());
            exp_q.delete();
        end
    endtask

    task automatic test_clear();
        bit early;
        logic [W-1:0] got, exp;
        mult = 4'd0;
        q_ready = 1'b1;
        send_bits(16'hFFFF, 7, 1, 1'b0, early);
        clear = 1'b1;
        enable = 1'b1;
        d = 1'b1;
        @(posedge clk); #1;
        clear = 1'b0;
        enable = 1'b0;
        checks++;
        if (q_valid !== 1'b0) begin
            errors++;
            $display("FAIL clear_novalid: v=%b want 0", q_valid);
        end
        exp_q.push_back(16'hC3C3);
        send_bits(16'hC3C3, 16, 1, 1'b0, early);
        checks++;
        if (early || q_valid !== 1'b1 || q !== 16'hC3C3) begin
            errors++;
            $display("FAIL clear_word: early=%b v=%b q=%h want 0/1/c3c3", early, q_valid, q);
        end
        idle(1);
        while (rx_q.size() > 0) begin
            got = rx_q.pop_front();
            exp = (exp_q.size() > 0) ? exp_q.pop_front() : 'x;
            checks++;
            if (got !== exp) begin
                errors++;
                $display("FAIL clear_sb: got=%h want %h", got, exp);
            end
        end
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL clear_missing: %0d words not seen", exp_q.size());
            exp_q.delete();
        end
    endtask

    task automatic test_async_reset();
        bit early;
        logic [W-1:0] got, exp;
        mult = 4'd0;
        q_ready = 1'b0;
        send_bits(16'h5A5A, 16, 1, 1'b0, early);
        send_bits(16'hFFFF, 9, 1, 1'b0, early);
        checks++;
        if (q_valid !== 1'b1) begin
            errors++;
            $display("FAIL areset_setup: v=%b want 1", q_valid);
        end
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if (q !== '0 || q_valid !== 1'b0 || overflow !== 1'b0) begin
            errors++;
            $display("FAIL areset_async: q=%h v=%b ovf=%b want 0/0/0", q, q_valid, overflow);
        end
        #1 rst_n = 1'b1;
        @(posedge clk); #1;
        q_ready = 1'b1;
        exp_q.push_back(16'h1E5B);
        send_bits(16'h1E5B, 16, 1, 1'b0, early);
        checks++;
        if (early || q_valid !== 1'b1 || q !== 16'h1E5B) begin
            errors++;
            $display("FAIL areset_fresh: early=%b v=%b q=%h want 0/1/1e5b", early, q_valid, q);
        end
        idle(1);
        while (rx_q.size() > 0) begin
            got = rx_q.pop_front();
            exp = (exp_q.size() > 0) ? exp_q.pop_front() : 'x;
            checks++;
            if (got !== exp) begin
                errors++;
                $display("FAIL areset_sb: got=%h want %h", got, exp);
            end
        end
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL areset_missing: %0d words not seen", exp_q.size());
            exp_q.delete();
        end
    endtask

    initial begin
        #2;
        test_reset();
        test_basic();
        test_repeat(1'b0);
        test_repeat(1'b1);
        test_overflow();
        test_back_to_back();
        test_clear();
        test_async_reset();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/pixel_packer.md
Name: pixel_packer

Overview:
- Serial-to-parallel counterpart of the display pixel serializer.
- Samples a 1-bit pixel stream at the pixel clock, decimates it by a programmable repeat factor, and packs the samples MSB-first into WIDTH-bit words.
- Presents each completed word on a valid/ready interface toward the framebuffer write port, for display readback, capture and self-test.

Parameters:
- WIDTH, 16, bits per packed word; legal range 2..32.

Ports:
- clk, input, 1, pixel clock; all state updates on the rising edge.
- rst_n, input, 1, asynchronous active-low reset.
- clear, input, 1, synchronous flush of the partial word; also resets the repeat counter.
- enable, input, 1, pixel strobe; the block advances only when it is high.
- mult, input, 4, pixel repeat factor less one; every (mult+1)th enabled cycle is sampled.
- d, input, 1, serial pixel in.
- q, output, WIDTH, packed word; the first sampled bit is in q[WIDTH-1].
- q_valid, output, 1, q holds an unconsumed word.
- q_ready, input, 1, consumer accepts q this cycle when q_valid is high.
- overflow, output, 1, one-cycle pulse when a completed word is dropped.

Behaviour:
- Reset (rst_n low, asynchronous): internal state clears to zero.
  - Cleared state: repeat counter, bit counter, shift register.
  - Outputs: q=0, q_valid=0, overflow=0.
  - Reset mid-word discards the partial word.
- Repeat counter (4 bits), per cycle:
  - If clear is high: counter <= 0.
  - Else if enable is high and counter==mult: take a sample this cycle; counter <= 0.
  - Else if enable is high: counter <= counter+1.
  - enable low: counter holds.
  - The first sample after reset or clear is taken on the (mult+1)th enabled cycle.
  - mult=0 samples on every enabled cycle.
  - If mult changes mid-count and the counter is already > mult, the counter wraps through 15 to 0 before the next sample. This is accepted behaviour and is not checked.
- Sampling:
  - Shift register update: sr <= {sr[WIDTH-2:0], d}.
  - Bit counter (ceil(log2 WIDTH) bits) increments on each sample.
  - On the sample where the bit counter equals WIDTH-1, the word completes. Completed word = {sr[WIDTH-2:0], d}.
  - On completion the bit counter returns to 0 and the shift register clears.
- Output register, evaluated each cycle. Let accept = q_valid & q_ready.
  - Completion and (!q_valid or accept): q <= completed word; q_valid <= 1. Back-to-back words are lossless when the consumer is ready.
  - Completion while q_valid and !q_ready: the completed word is dropped; q and q_valid are unchanged; overflow=1 for that cycle.
  - No completion and accept: q_valid <= 0; q holds its last value.
  - q and q_valid change only on completion or accept.
- Latency: q_valid rises on the clock edge that takes the WIDTH-th sample. It is visible in the cycle after that sample.
- clear:
  - Wins over enable in the same cycle; no sample is taken.
  - Discards the partial word.
  - Does not affect q, q_valid or a pending accept.
- q_ready while q_valid=0 has no effect.
- overflow is registered and is never high for two consecutive cycles unless completions occur in consecutive cycles. That requires WIDTH samples per word, so it is impossible for WIDTH >= 2.

Test Plan:
- Reset, mult=0, enable=1, q_ready=1, d stream 1010_0000_1111_0001 (first bit first) -> q_valid pulses one cycle after the 16th bit; q=16'hA0F1; overflow stays 0.
- mult=2, enable=1 continuously, each bit held 3 cycles, pattern 16'h8001 -> q=16'h8001 after exactly 48 enabled cycles. Repeat with enable toggling 1/0 -> same word after 48 enabled (96 total) cycles.
- q_ready=0, two full words 16'h1234 then 16'hBEEF -> q=16'h1234, q_valid=1; overflow pulses once on the 32nd sample; 16'hBEEF is lost. Then q_ready=1 for one cycle -> q_valid=0.
- q_ready=1 held, continuous mult=0 stream of 16'hFFFF then 16'h0000 -> two valid words on consecutive word boundaries; no overflow.
- Feed 7 bits, assert clear for one cycle with enable=1, then feed 16'hC3C3 -> q=16'hC3C3; the earlier partial bits do not appear.
- Deassert rst_n asynchronously after 9 bits of a word, with q_valid=1 pending -> q=0, q_valid=0, overflow=0 immediately without a clock edge; the next 16 samples form a fresh word.
